alu_mdu_seq: RTL
================

Name: alu_mdu_seq

Overview:
- Parametrised successor to the combinational core ALU. Adds registered results, a valid/ready handshake, and iterative multi-cycle multiply, divide and remainder.
- Sits in the EX stage. The pipeline stalls on in_ready_o low or out_valid_o low.
- Basic ops complete in 1 cycle. MUL/DIV/REM take WIDTH iteration cycles. Zero and negative flags are produced with every result.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of 2, at least 8.
- SHAMT_W, $clog2(WIDTH), number of low bits of b used as shift amount (derived; do not override).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset (see Behaviour)
- in_valid_i  input  1  operation request
- in_ready_o  output  1  block can accept a request
- alu_op_i  input  4  operation code
- alu_a_i  input  WIDTH  operand a
- alu_b_i  input  WIDTH  operand b
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- alu_c_o  output  WIDTH  result
- zero_o  output  1  result == 0
- neg_o  output  1  result MSB

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=IDLE, in_ready_o=1, out_valid_o=0, alu_c_o=0, zero_o=1, neg_o=0. Internal counter and accumulators cleared.
- Reset mid-operation aborts the computation; no result is emitted.
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 0/1), 9 SLTU, 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU, 14 DIV, 15 REM.
- Arithmetic rules: results are modulo 2^WIDTH. Shifts use b[SHAMT_W-1:0]. DIV/REM truncate toward zero; the remainder takes the sign of the dividend.
- Operand capture: a request is accepted when in_valid_i && in_ready_o. Op and operands are registered; later input changes have no effect.
- FSM states: IDLE, CALC, DONE.
  - IDLE, accept of ops 0-9 -> DONE next edge. Latency 1: out_valid_o high the cycle after accept.
  - IDLE, accept of ops 10-15 -> CALC. Counter is loaded with WIDTH.
  - CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle; counter decrements. When the counter reaches 1, the final step is taken and the state moves to DONE. Accept-to-out_valid latency is exactly WIDTH+1 cycles.
  - Signed DIV/REM: operands are converted to magnitudes at accept; quotient and remainder signs are fixed on entry to DONE with no extra cycle.
  - DONE: out_valid_o=1. alu_c_o, zero_o and neg_o are stable until out_ready_i. On out_valid_o && out_ready_i -> IDLE.
- in_ready_o: 1 only in IDLE. There is no pass-through; the next request is accepted at the earliest the cycle after the result handshake.
- Divide special cases (these skip CALC; latency 1):
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU result = dividend.
  - DIV with a = most-negative and b = -1: quotient = most-negative; REM result = 0.
- Flags: zero_o and neg_o are computed from the final result and registered with alu_c_o. They are valid only while out_valid_o=1.
- out_ready_i held high in DONE: the result is consumed in one cycle. out_valid_o is not asserted in CALC.
- in_valid_i while busy: ignored, not queued. The requester must hold it until in_ready_o.

Test Plan:
- Reset then basic op (WIDTH=32): after rst_i pulse, outputs equal reset values. ADD a=0x7FFFFFFF, b=1 -> one cycle later out_valid_o=1, alu_c_o=0x80000000, neg_o=1, zero_o=0.
- Shifts and compares: SRA a=0x80000000, b=0x24 (shamt 4) -> 0xF8000000. SLT a=0xFFFFFFFF, b=1 -> 1. SLTU same operands -> 0. SUB 5-5 -> 0 with zero_o=1.
- Multiply: MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000001. MULHU same operands -> 0xFFFFFFFE. out_valid_o rises exactly 33 cycles after accept; in_ready_o=0 throughout.
- Division: DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Division corner cases: DIVU x/0 -> 0xFFFFFFFF. REM 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. All have latency 1.
- Backpressure and reset: hold out_ready_i=0 for 10 cycles in DONE -> result and flags stable, in_ready_o=0. Then assert rst_i mid-CALC of a DIV -> next cycle out_valid_o=0, in_ready_o=1, and no result appears afterwards.

Source files
------------

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: registered ALU with valid/ready handshake and iterative multiply/divide.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   in_valid_i   request valid; in_ready_o high only while idle
//   alu_op_i     operation code (0 ADD .. 15 REM)
//   alu_a_i      operand a
//   alu_b_i      operand b
//   out_valid_o  result valid; held until out_ready_i
//   out_ready_i  consumer accepts the result
//   alu_c_o      result
//   zero_o       result == 0 (valid with out_valid_o)
//   neg_o        result MSB (valid with out_valid_o)
//
// Ops 0-9 and divide special cases complete in one cycle. MUL/MULHU/DIVU/REMU/DIV/REM run
// WIDTH shift-add or restoring-subtract steps in CALC.
module alu_mdu_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       alu_op_i,
    input  logic [WIDTH-1:0] alu_a_i,
    input  logic [WIDTH-1:0] alu_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] alu_c_o,
    output logic             zero_o,
    output logic             neg_o
);

    localparam int unsigned CntW = SHAMT_W + 1;

    localparam logic [3:0] OpAdd   = 4'd0;
    localparam logic [3:0] OpSub   = 4'd1;
    localparam logic [3:0] OpAnd   = 4'd2;
    localparam logic [3:0] OpOr    = 4'd3;
    localparam logic [3:0] OpXor   = 4'd4;
    localparam logic [3:0] OpSll   = 4'd5;
    localparam logic [3:0] OpSrl   = 4'd6;
    localparam logic [3:0] OpSra   = 4'd7;
    localparam logic [3:0] OpSlt   = 4'd8;
    localparam logic [3:0] OpSltu  = 4'd9;
    localparam logic [3:0] OpMul   = 4'd10;
    localparam logic [3:0] OpMulhu = 4'd11;
    localparam logic [3:0] OpDivu  = 4'd12;
    localparam logic [3:0] OpRemu  = 4'd13;
    localparam logic [3:0] OpDiv   = 4'd14;
    localparam logic [3:0] OpRem   = 4'd15;

    localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d;     // product high half / partial remainder
    logic [WIDTH-1:0]   lo_q, lo_d;     // multiplier / dividend, becomes product low / quotient
    logic [WIDTH-1:0]   opb_q, opb_d;   // multiplicand / divisor magnitude
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               negf_q, negf_d;

    logic [WIDTH-1:0]   basic_res;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic               is_sdiv;
    logic [WIDTH-1:0]   a_mag, b_mag;

    // Single-cycle ops, computed straight from the request inputs.
    always_comb begin
        shamt     = alu_b_i[SHAMT_W-1:0];
        basic_res = '0;
        case (alu_op_i)
            OpAdd:   basic_res = alu_a_i + alu_b_i;
            OpSub:   basic_res = alu_a_i - alu_b_i;
            OpAnd:   basic_res = alu_a_i & alu_b_i;
            OpOr:    basic_res = alu_a_i | alu_b_i;
            OpXor:   basic_res = alu_a_i ^ alu_b_i;
            OpSll:   basic_res = alu_a_i << shamt;
            OpSrl:   basic_res = alu_a_i >> shamt;
            OpSra:   basic_res = $unsigned($signed(alu_a_i) >>> shamt);
            OpSlt:   basic_res = {{(WIDTH-1){1'b0}}, $signed(alu_a_i) < $signed(alu_b_i)};
            OpSltu:  basic_res = {{(WIDTH-1){1'b0}}, alu_a_i < alu_b_i};
            default: basic_res = '0;
        endcase
    end

    // One iteration step for both the multiplier and the divider.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb_q};
        if (op_q[3:2] == 2'b11) begin
            // The true difference is below the divisor, so WIDTH bits always hold it.
            step_hi = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        is_sdiv = (alu_op_i == OpDiv) || (alu_op_i == OpRem);
        a_mag   = alu_a_i[WIDTH-1] ? -alu_a_i : alu_a_i;
        b_mag   = alu_b_i[WIDTH-1] ? -alu_b_i : alu_b_i;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    op_d = alu_op_i;
                    if (alu_op_i < OpMul) begin
                        res_d   = basic_res;
                        state_d = StDone;
                    end else if (alu_op_i[3:2] == 2'b11 && alu_b_i == '0) begin
                        res_d   = alu_op_i[0] ? alu_a_i : '1;
                        state_d = StDone;
                    end else if (is_sdiv && alu_a_i == MostNeg && alu_b_i == '1) begin
                        res_d   = alu_op_i[0] ? '0 : MostNeg;
                        state_d = StDone;
                    end else begin
                        hi_d    = '0;
                        lo_d    = is_sdiv ? a_mag : alu_a_i;
                        opb_d   = is_sdiv ? b_mag : alu_b_i;
                        cnt_d   = CntW'(WIDTH);
                        qneg_d  = is_sdiv && (alu_a_i[WIDTH-1] ^ alu_b_i[WIDTH-1]);
                        rneg_d  = is_sdiv && alu_a_i[WIDTH-1];
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    // Signs are applied here so the result lands with no extra cycle.
                    case (op_q)
                        OpMulhu: res_d = step_hi;
                        OpRemu:  res_d = step_hi;
                        OpDiv:   res_d = qneg_q ? -step_lo : step_lo;
                        OpRem:   res_d = rneg_q ? -step_hi : step_hi;
                        default: res_d = step_lo;
                    endcase
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        zero_d = (res_d == '0);
        negf_d = res_d[WIDTH-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            negf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            negf_q  <= negf_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign alu_c_o     = res_q;
    assign zero_o      = zero_q;
    assign neg_o       = negf_q;

endmodule
